pwm_multi_gen: RTL and testbench

Parametrised multi-channel PWM generator. It replaces the single-channel, 10-bit, free-running PWM_Generator in the motor/LED drive path. It adds:
- per-channel duty registers with shadow double-buffering, so updates are glitch-free at period boundaries;
- a programmable clock prescaler;
- edge-aligned or center-aligned counting;
- a period-start strobe for downstream sampling logic.

---
 rtl/pwm_multi_gen.sv | 126 ++++++++++++
 tb/tb_pwm_multi_gen.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_multi_gen.sv
// Multi-channel PWM generator with a shared prescaled counter and double-buffered duties.
// Edge-aligned or center-aligned counting, with a registered strobe at each period boundary.
module pwm_multi_gen #(
    parameter int CHANNELS   = 4,
    parameter int WIDTH      = 10,
    parameter int PRESCALE_W = 8,
    localparam int CH_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  mode,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic                  wr_en,
    input  logic [CH_W-1:0]       wr_ch,
    input  logic [WIDTH-1:0]      wr_duty,
    output logic [CHANNELS-1:0]   pwm_out,
    output logic                  period_start
);

    localparam logic [WIDTH-1:0] MAX = {WIDTH{1'b1}};

    logic [PRESCALE_W-1:0] presc_q, presc_d;
    logic [WIDTH-1:0]      cnt_q, cnt_d;
    logic                  down_q, down_d;
    logic                  mode_q, mode_d;
    logic                  en_q;
    logic [WIDTH-1:0]      shadow_q [CHANNELS];
    logic [WIDTH-1:0]      shadow_d [CHANNELS];
    logic [WIDTH-1:0]      active_q [CHANNELS];
    logic [WIDTH-1:0]      active_d [CHANNELS];
    logic [CHANNELS-1:0]   pwm_q, pwm_d;
    logic                  pstart_q, pstart_d;
    logic                  tick;
    logic                  wrap;
    logic                  boundary;

    // Duty 0 and MAX are pinned so that both 0% and 100% are reachable.
    function automatic logic duty_cmp(input logic [WIDTH-1:0] cnt, input logic [WIDTH-1:0] duty);
        if (duty == '0) begin
            return 1'b0;
        end
        if (duty == MAX) begin
            return 1'b1;
        end
        return cnt < duty;
    endfunction

    always_comb begin
        tick     = enable && (presc_q >= prescale);
        wrap     = mode_q ? (down_q && (cnt_q == WIDTH'(1))) : (cnt_q == MAX);
        // The first enabled cycle counts as a boundary so the counter starts at 0.
        boundary = enable && ((tick && wrap) || !en_q);

        for (int i = 0; i < CHANNELS; i++) begin
            shadow_d[i] = (wr_en && (wr_ch == CH_W'(i))) ? wr_duty : shadow_q[i];
            active_d[i] = (!enable || boundary) ? shadow_d[i] : active_q[i];
        end
        mode_d = (!enable || boundary) ? mode : mode_q;

        presc_d  = '0;
        cnt_d    = '0;
        down_d   = 1'b0;
        pwm_d    = '0;
        pstart_d = 1'b0;
        if (enable) begin
            pstart_d = boundary;
            if (!boundary) begin
                presc_d = tick ? '0 : presc_q + 1'b1;
                cnt_d   = cnt_q;
                down_d  = down_q;
                if (tick) begin
                    if (!mode_q) begin
                        cnt_d = cnt_q + 1'b1;
                    end else if (!down_q) begin
                        if (cnt_q == MAX) begin
                            cnt_d  = cnt_q - 1'b1;
                            down_d = 1'b1;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
            end
            if (en_q) begin
                for (int i = 0; i < CHANNELS; i++) begin
                    pwm_d[i] = duty_cmp(cnt_q, active_q[i]);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q  <= '0;
            cnt_q    <= '0;
            down_q   <= 1'b0;
            mode_q   <= 1'b0;
            en_q     <= 1'b0;
            pwm_q    <= '0;
            pstart_q <= 1'b0;
            for (int i = 0; i < CHANNELS; i++) begin
                shadow_q[i] <= '0;
                active_q[i] <= '0;
            end
        end else begin
            presc_q  <= presc_d;
            cnt_q    <= cnt_d;
            down_q   <= down_d;
            mode_q   <= mode_d;
            en_q     <= enable;
            pwm_q    <= pwm_d;
            pstart_q <= pstart_d;
            for (int i = 0; i < CHANNELS; i++) begin
                shadow_q[i] <= shadow_d[i];
                active_q[i] <= active_d[i];
            end
        end
    end

    assign pwm_out      = pwm_q;
    assign period_start = pstart_q;

endmodule

// File: tb/tb_pwm_multi_gen.sv
// Directed bench for pwm_multi_gen: per-period high-time tables plus corner-case sequences.
// A second, narrow 3-channel instance shares the inputs to exercise out-of-range channel writes.
module tb_pwm_multi_gen;

    localparam int CH = 4;
    localparam int W  = 10;
    localparam int PW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          enable = 1'b0;
    logic          mode = 1'b0;
    logic [PW-1:0] prescale = '0;
    logic          wr_en = 1'b0;
    logic [1:0]    wr_ch = '0;
    logic [W-1:0]  wr_duty = '0;
    logic [CH-1:0] pwm_out;
    logic          period_start;
    logic [3:0]    wr_duty3;
    logic [2:0]    pwm3;
    logic          ps3;

    int checks = 0;
    int errors = 0;
    int hi_cnt [CH];
    int hi3_cnt [3];
    int ps_cnt;
    int ps3_cnt;

    typedef struct packed {
        logic [3:0][9:0]  duty;
        logic [7:0]       ps;
        logic             md;
        logic [12:0]      win;
        logic [3:0][12:0] hi;
    } vec_t;

    vec_t vecs [4];

    assign wr_duty3 = wr_duty[3:0];

    always #5 clk = ~clk;

    pwm_multi_gen #(.CHANNELS(4), .WIDTH(10), .PRESCALE_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .mode(mode), .prescale(prescale),
        .wr_en(wr_en), .wr_ch(wr_ch), .wr_duty(wr_duty),
        .pwm_out(pwm_out), .period_start(period_start)
    );

    pwm_multi_gen #(.CHANNELS(3), .WIDTH(4), .PRESCALE_W(8)) dut3 (
        .clk(clk), .rst_n(rst_n), .enable(enable), .mode(mode), .prescale(prescale),
        .wr_en(wr_en), .wr_ch(wr_ch), .wr_duty(wr_duty3),
        .pwm_out(pwm3), .period_start(ps3)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic write_duty(input int ch, input int d);
        wr_en   = 1'b1;
        wr_ch   = 2'(ch);
        wr_duty = W'(d);
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    task automatic go_idle();
        enable = 1'b0;
        @(negedge clk);
    endtask

    // Leaves the bench at the negedge of the first cycle with the counter at 0.
    task automatic start_run();
        enable = 1'b1;
        @(negedge clk);
    endtask

    task automatic measure(input int n);
        for (int c = 0; c < CH; c++) hi_cnt[c] = 0;
        for (int c = 0; c < 3; c++) hi3_cnt[c] = 0;
        ps_cnt  = 0;
        ps3_cnt = 0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            for (int c = 0; c < CH; c++) hi_cnt[c] += int'(pwm_out[c]);
            for (int c = 0; c < 3; c++) hi3_cnt[c] += int'(pwm3[c]);
            ps_cnt  += int'(period_start);
            ps3_cnt += int'(ps3);
        end
    endtask

    initial begin
        #10_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int p1, p2, p3, pulses;

        vecs[0].duty = {10'd1023, 10'd512, 10'd256, 10'd0};
        vecs[0].ps = 8'd0; vecs[0].md = 1'b0; vecs[0].win = 13'd1024;
        vecs[0].hi = {13'd1024, 13'd512, 13'd256, 13'd0};
        vecs[1].duty = {10'd0, 10'd1023, 10'd1, 10'd256};
        vecs[1].ps = 8'd3; vecs[1].md = 1'b0; vecs[1].win = 13'd4096;
        vecs[1].hi = {13'd0, 13'd4096, 13'd4, 13'd1024};
        vecs[2].duty = {10'd1023, 10'd512, 10'd1, 10'd256};
        vecs[2].ps = 8'd0; vecs[2].md = 1'b1; vecs[2].win = 13'd2046;
        vecs[2].hi = {13'd2046, 13'd1023, 13'd1, 13'd511};
        vecs[3].duty = {10'd0, 10'd1, 10'd2, 10'd3};
        vecs[3].ps = 8'd1; vecs[3].md = 1'b0; vecs[3].win = 13'd2048;
        vecs[3].hi = {13'd0, 13'd2, 13'd4, 13'd6};

        repeat (2) @(negedge clk);
        check("reset_pwm", int'(pwm_out), 0);
        check("reset_pstart", int'(period_start), 0);
        check("reset_pwm3", int'(pwm3), 0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int v = 0; v < 4; v++) begin
            enable   = 1'b0;
            prescale = vecs[v].ps;
            mode     = vecs[v].md;
            @(negedge clk);
            check($sformatf("v%0d_idle_pwm", v), int'(pwm_out), 0);
            check($sformatf("v%0d_idle_pstart", v), int'(period_start), 0);
            for (int c = 0; c < CH; c++) write_duty(c, int'(vecs[v].duty[c]));
            start_run();
            check($sformatf("v%0d_first_pstart", v), int'(period_start), 1);
            measure(int'(vecs[v].win));
            for (int c = 0; c < CH; c++)
                check($sformatf("v%0d_hi_ch%0d", v, c), hi_cnt[c], int'(vecs[v].hi[c]));
            check($sformatf("v%0d_pulses", v), ps_cnt, 1);
        end

        // Shadow double-buffer: mid-period write waits, boundary-cycle write bypasses.
        go_idle();
        prescale = '0;
        mode     = 1'b0;
        write_duty(0, 256);
        for (int c = 1; c < CH; c++) write_duty(c, 0);
        start_run();
        p1 = 0; p2 = 0; p3 = 0; pulses = 0;
        for (int k = 1; k <= 3072; k++) begin
            @(negedge clk);
            if (k <= 1024) p1 += int'(pwm_out[0]);
            else if (k <= 2048) p2 += int'(pwm_out[0]);
            else p3 += int'(pwm_out[0]);
            pulses += int'(period_start);
            if (k == 100 || k == 2047) begin
                wr_en   = 1'b1;
                wr_ch   = 2'd0;
                wr_duty = (k == 100) ? W'(768) : W'(100);
            end else begin
                wr_en = 1'b0;
            end
        end
        check("shadow_p1_hi", p1, 256);
        check("shadow_p2_hi", p2, 768);
        check("boundary_write_p3_hi", p3, 100);
        check("shadow_pulses", pulses, 3);

        // Lowering prescale below the running prescaler count ticks immediately.
        go_idle();
        prescale = 8'd3;
        write_duty(0, 10);
        start_run();
        p1 = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            p1 += int'(pwm_out[0]);
            if (k == 22) prescale = 8'd1;
        end
        check("presc_change_hi", p1, 31);

        // Disable mid-period.
        go_idle();
        prescale = '0;
        write_duty(3, 1023);
        start_run();
        repeat (10) @(negedge clk);
        check("pre_disable_ch3", int'(pwm_out[3]), 1);
        enable = 1'b0;
        @(negedge clk);
        check("disable_pwm", int'(pwm_out), 0);
        check("disable_pstart", int'(period_start), 0);

        // Asynchronous reset mid-period clears everything including duties.
        for (int c = 0; c < CH; c++) write_duty(c, 512);
        start_run();
        repeat (100) @(negedge clk);
        check("pre_reset_pwm", int'(pwm_out), 15);
        #2 rst_n = 1'b0;
        #1 check("reset_async_pwm", int'(pwm_out), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        measure(1100);
        for (int c = 0; c < CH; c++)
            check($sformatf("post_reset_hi_ch%0d", c), hi_cnt[c], 0);

        // Channel 3 does not exist on the 3-channel instance; that write must be ignored.
        go_idle();
        write_duty(0, 5);
        write_duty(3, 15);
        start_run();
        check("n3_first_pstart", int'(ps3), 1);
        measure(16);
        check("n3_hi_ch0", hi3_cnt[0], 5);
        check("n3_hi_ch1", hi3_cnt[1], 0);
        check("n3_hi_ch2", hi3_cnt[2], 0);
        check("n3_pulses", ps3_cnt, 1);
        check("n4_hi_ch3", hi_cnt[3], 15);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
